pipeline_stall_controller: RTL and testbench

- Central sequencer for the 5-stage MIPS32 pipeline register enables, flushes and bubbles.
- Merges the following events into one consistent set of per-stage controls:
  - the hazard unit's stall requests: load-use and branch-operand;
  - ID-stage taken branches;
  - multi-cycle data-memory waits;
  - the multi-cycle mul/div unit in EX.
- Adds a wait watchdog and a stall-cycle counter.
- Sits beside the hazard unit. Drives PC and all pipeline register enable/flush pins.

---
 rtl/pipeline_stall_controller.sv | 164 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central sequencer for the 5-stage MIPS32 pipeline. It merges hazard-unit
//   stalls, ID-stage taken branches, multi-cycle data-memory waits and the
//   multi-cycle mul/div unit into one consistent set of PC and pipeline
//   register enable/flush controls. It also has a wait watchdog and a
//   saturating stall-cycle counter.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   hz_stall            load-use / branch-operand stall from the hazard unit
//   id_branch_taken     branch/jump resolved taken in ID this cycle
//   mem_req, mem_ready  MEM-stage access request / completion
//   muldiv_start/done   mul/div unit request in EX / result valid
//   pc_enable, *_enable per-register load enables
//   *_flush             per-register bubble/NOP insertion
//   busy_state          0 RUN, 1 MEM_WAIT, 2 MULDIV_BUSY
//   timeout_err         sticky watchdog flag
//   stall_cycles        saturating count of cycles with pc_enable low
module pipeline_stall_controller #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hz_stall,
    input  logic             id_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             muldiv_start,
    input  logic             muldiv_done,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_enable,
    output logic             id_ex_flush,
    output logic             ex_mem_enable,
    output logic             ex_mem_flush,
    output logic             mem_wb_enable,
    output logic             mem_wb_flush,
    output logic [1:0]       busy_state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        MULDIV_BUSY = 2'd2
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mem_freeze;
    logic                muldiv_hold;
    logic                wait_expired;

    assign mem_freeze   = mem_req & ~mem_ready;
    // The cycle muldiv_done rises already behaves like RUN so EX/MEM captures the result.
    assign muldiv_hold  = (state == MULDIV_BUSY) & ~muldiv_done;
    // The counter holds the number of wait cycles already completed; this one is the last allowed.
    assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign busy_state   = state;

    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_enable = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_enable = 1'b1;
        mem_wb_flush  = 1'b0;
        if (reset) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_enable  = 1'b0;
            id_ex_flush   = 1'b1;
            ex_mem_enable = 1'b0;
            ex_mem_flush  = 1'b1;
            mem_wb_enable = 1'b0;
            mem_wb_flush  = 1'b1;
        end else if (mem_freeze) begin
            // Whole pipeline frozen; WB gets a bubble so nothing retires twice.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            mem_wb_flush  = 1'b1;
        end else if (muldiv_hold) begin
            // Hold IF..EX, let older instructions drain behind a bubble.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_flush  = 1'b1;
        end else if (hz_stall) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_flush   = 1'b1;
        end else if (id_branch_taken) begin
            // Only reached with pc_enable high; a stalled branch is re-presented later.
            if_id_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_freeze)
                        state <= MEM_WAIT;
                    else if (muldiv_start & ~muldiv_done)
                        state <= MULDIV_BUSY;
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state       <= RUN;
                        wait_cnt    <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MULDIV_BUSY: begin
                    // A memory freeze only overrides outputs; the state and watchdog keep running.
                    if (muldiv_done) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state       <= RUN;
                        wait_cnt    <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (!pc_enable && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller. Two instances share stimulus:
// dut_a uses the default parameters, dut_b uses CNT_W=3, MAX_WAIT=4 for the
// watchdog and saturation cases. Expected values are queued per cycle and
// checked by a separate monitor on the falling edge.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic reset, hz_stall, id_branch_taken, mem_req, mem_ready, muldiv_start, muldiv_done;

    logic a_pc, a_ife, a_iff, a_iee, a_ief, a_eme, a_emf, a_mwe, a_mwf, a_to;
    logic [1:0]  a_bs;
    logic [31:0] a_sc;
    logic b_pc, b_ife, b_iff, b_iee, b_ief, b_eme, b_emf, b_mwe, b_mwf, b_to;
    logic [1:0]  b_bs;
    logic [2:0]  b_sc;

    always #5 clk = ~clk;

    pipeline_stall_controller dut_a (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .id_branch_taken(id_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
        .pc_enable(a_pc), .if_id_enable(a_ife), .if_id_flush(a_iff), .id_ex_enable(a_iee),
        .id_ex_flush(a_ief), .ex_mem_enable(a_eme), .ex_mem_flush(a_emf), .mem_wb_enable(a_mwe),
        .mem_wb_flush(a_mwf), .busy_state(a_bs), .timeout_err(a_to), .stall_cycles(a_sc)
    );

    pipeline_stall_controller #(.CNT_W(3), .MAX_WAIT(4)) dut_b (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .id_branch_taken(id_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
        .pc_enable(b_pc), .if_id_enable(b_ife), .if_id_flush(b_iff), .id_ex_enable(b_iee),
        .id_ex_flush(b_ief), .ex_mem_enable(b_eme), .ex_mem_flush(b_emf), .mem_wb_enable(b_mwe),
        .mem_wb_flush(b_mwf), .busy_state(b_bs), .timeout_err(b_to), .stall_cycles(b_sc)
    );

    logic [8:0] ctl_a, ctl_b;
    assign ctl_a = {a_pc, a_ife, a_iff, a_iee, a_ief, a_eme, a_emf, a_mwe, a_mwf};
    assign ctl_b = {b_pc, b_ife, b_iff, b_iee, b_ief, b_eme, b_emf, b_mwe, b_mwf};

    // {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, ex_mem_fl, mem_wb_en, mem_wb_fl}
    localparam logic [8:0] C_RUN = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_RST = 9'b0_0_1_0_1_0_1_0_1;
    localparam logic [8:0] C_FRZ = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] C_MDH = 9'b0_0_0_0_0_1_1_1_0;
    localparam logic [8:0] C_HZ  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] C_BR  = 9'b1_1_1_1_0_1_0_1_0;

    typedef struct {
        string       name;
        bit          sel;
        bit          chk_ctl;
        logic [8:0]  ctl;
        logic [1:0]  bs;
        logic        to;
        bit          chk_sc;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    task automatic step(input string name, input logic rs, hz, br, mq, mr, ms, md,
                        input bit sel, input bit chk_ctl, input logic [8:0] ctl,
                        input logic [1:0] bs, input logic to, input bit chk_sc,
                        input logic [31:0] sc);
        exp_t e;
        reset = rs; hz_stall = hz; id_branch_taken = br;
        mem_req = mq; mem_ready = mr; muldiv_start = ms; muldiv_done = md;
        e.name = name; e.sel = sel; e.chk_ctl = chk_ctl; e.ctl = ctl;
        e.bs = bs; e.to = to; e.chk_sc = chk_sc; e.sc = sc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pushed cycle is checked on the falling edge of that cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0]  act_ctl;
            logic [1:0]  act_bs;
            logic        act_to;
            logic [31:0] act_sc;
            e = q.pop_front();
            act_ctl = e.sel ? ctl_b : ctl_a;
            act_bs  = e.sel ? b_bs : a_bs;
            act_to  = e.sel ? b_to : a_to;
            act_sc  = e.sel ? {29'd0, b_sc} : a_sc;
            compared++;
            if ((e.chk_ctl && act_ctl !== e.ctl) || act_bs !== e.bs || act_to !== e.to) begin
                mismatched++;
                $display("FAIL %s: ctl=%b busy=%0d to=%b, required ctl=%b busy=%0d to=%b (ctl checked=%0d)",
                         e.name, act_ctl, act_bs, act_to, e.ctl, e.bs, e.to, e.chk_ctl);
            end
            if (e.chk_sc) begin
                compared++;
                if (act_sc !== e.sc) begin
                    mismatched++;
                    $display("FAIL %s stall_cycles: got %0d, required %0d", e.name, act_sc, e.sc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; hz_stall = 1'b0; id_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; muldiv_start = 1'b0; muldiv_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //    name           rs hz br mq mr ms md sel chk ctl    bs to chk_sc sc
        step("reset_hold",   1, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, 0, 0, 1, 0);
        step("reset_rel",    0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 1, 0);
        step("idle",         0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 0, 0);
        step("hz_and_br",    0, 1, 1, 0, 0, 0, 0, 0, 1, C_HZ,  0, 0, 1, 0);
        step("br_only",      0, 0, 1, 0, 0, 0, 0, 0, 1, C_BR,  0, 0, 1, 1);
        step("idle2",        0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 1, 1);
        // multi-cycle memory access: three not-ready cycles then ready
        step("mem_w0",       0, 0, 0, 1, 0, 0, 0, 0, 1, C_FRZ, 0, 0, 1, 1);
        step("mem_w1",       0, 0, 0, 1, 0, 0, 0, 0, 1, C_FRZ, 1, 0, 1, 2);
        step("mem_w2",       0, 0, 0, 1, 0, 0, 0, 0, 1, C_FRZ, 1, 0, 1, 3);
        step("mem_ready",    0, 0, 0, 1, 1, 0, 0, 0, 1, C_RUN, 1, 0, 1, 4);
        step("mem_after",    0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 1, 4);
        // mul/div with a two-cycle memory freeze in the middle
        step("md_start",     0, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN, 0, 0, 0, 0);
        step("md_b1",        0, 0, 0, 0, 0, 1, 0, 0, 1, C_MDH, 2, 0, 0, 0);
        step("md_frz1",      0, 0, 0, 1, 0, 1, 0, 0, 1, C_FRZ, 2, 0, 0, 0);
        step("md_frz2",      0, 0, 0, 1, 0, 1, 0, 0, 1, C_FRZ, 2, 0, 0, 0);
        step("md_b4",        0, 0, 0, 1, 1, 1, 0, 0, 1, C_MDH, 2, 0, 0, 0);
        step("md_done",      0, 0, 0, 0, 0, 0, 1, 0, 1, C_RUN, 2, 0, 0, 0);
        step("md_after",     0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 0, 0);
        // single-cycle mul/div and single-cycle memory stay in RUN
        step("md_1cyc",      0, 0, 0, 0, 0, 1, 1, 0, 1, C_RUN, 0, 0, 0, 0);
        step("md_1cyc_nx",   0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 0, 0);
        step("mem_1cyc",     0, 0, 0, 1, 1, 0, 0, 0, 1, C_RUN, 0, 0, 0, 0);
        step("mem_1cyc_nx",  0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 0, 0);
        // reset in the middle of MULDIV_BUSY
        step("md2_start",    0, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN, 0, 0, 0, 0);
        step("md2_busy",     0, 0, 0, 0, 0, 0, 0, 0, 1, C_MDH, 2, 0, 0, 0);
        step("md2_reset",    1, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, 0, 0, 1, 0);
        step("md2_rel",      0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0, 1, 0);
        // watchdog on dut_b (MAX_WAIT=4), memory never ready
        step("wd_enter",     0, 0, 0, 1, 0, 0, 0, 1, 1, C_FRZ, 0, 0, 1, 0);
        step("wd_w1",        0, 0, 0, 1, 0, 0, 0, 1, 1, C_FRZ, 1, 0, 0, 0);
        step("wd_w2",        0, 0, 0, 1, 0, 0, 0, 1, 1, C_FRZ, 1, 0, 0, 0);
        step("wd_w3",        0, 0, 0, 1, 0, 0, 0, 1, 1, C_FRZ, 1, 0, 0, 0);
        step("wd_w4",        0, 0, 0, 1, 0, 0, 0, 1, 1, C_FRZ, 1, 0, 1, 4);
        step("wd_fired",     0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 1, 1, 5);
        step("wd_sticky",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 1, 1, 5);
        // saturation of the 3-bit stall counter
        for (int i = 0; i < 10; i++)
            step("sat_hz",   0, 1, 0, 0, 0, 0, 0, 1, 1, C_HZ,  0, 1, 1, ((5 + i) > 7) ? 32'd7 : 32'(5 + i));
        step("sat_hold",     0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 1, 1, 7);
        step("b_reset",      1, 0, 0, 0, 0, 0, 0, 1, 1, C_RST, 0, 0, 1, 0);
        step("b_rel",        0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
